layer1_mac: RTL and testbench
=============================

# layer1_mac

Multiply-accumulate stage for one neuron of the layer-1 datapath in the XOR network. It sits beside the layer-1 term counter and consumes that counter's `ack__mac` completion flag. On every `ack` strobe it accumulates one signed `x*w` product. When `ack__mac` rises, it freezes the sum, rescales it to the neuron's fixed-point format and presents it with a held valid flag to the activation stage downstream.

## Interface
- `WIDTH`, 8: signed two's-complement width of `x`, `w` and `y`.
- `FRAC`, 4: fractional bits of the fixed-point format. Shared by `x`, `w` and `y`.
- `ACC_WIDTH`, 18: signed accumulator width. Must be ≥ 2·WIDTH + ceil(log2(terms per neuron)).
- `clk`  in  1  clock. All state updates on the falling edge, same as the counter stage.
- `rst`  in  1  reset. Synchronous, active-low: sampled on the falling edge while low.
- `ack`  in  1  term strobe. Same signal that drives the counter stage.
- `ack__mac`  in  1  counter completion flag. Level-high once the last term is counted; stays high until counter reset.
- `x`  in  WIDTH  signed input activation. Valid when `ack`=1.
- `w`  in  WIDTH  signed weight. Valid when `ack`=1.
- `y`  out  WIDTH  signed neuron pre-activation result.
- `y_valid`  out  1  result valid. Held high until reset or re-arm.

## Operation
- Reset (`rst`=0 at a falling edge): `acc`=0, `y`=0, `y_valid`=0, `mac_d`=0, state=ACCUM. Reset has priority over every other input.
- `mac_d` is a registered copy of `ack__mac`, used for edge detection. `rise` = `ack__mac` & ~`mac_d`; `fall` = ~`ack__mac` & `mac_d`.
- State ACCUM:
  - `ack`=1 and `rise`=0: `acc` ← `acc` + sext(`x`·`w`). The product is a full 2·WIDTH signed value.
  - `rise`=1: the term count is complete. Go to DONE. Load `y` ← fmt(`acc`) and set `y_valid` ← 1. An `ack` in the same cycle is ignored and not accumulated.
- State DONE:
  - `ack` is ignored. `acc`, `y` and `y_valid` hold.
  - `fall`=1 means the counter was reset for the next inference. Clear `acc` to 0, set `y_valid` ← 0 and go to ACCUM. `y` keeps its last value.
- fmt(a): arithmetic shift right by `FRAC`, which floors toward −∞. The result is then narrowed to `WIDTH` per Configuration.
- `ack__mac` already high when leaving reset: `mac_d` is 0, so `rise` fires on the first edge and `y` = fmt(0) = 0. This is intended behaviour.
- `acc` never overflows while `ACC_WIDTH` meets the rule above. Overflow beyond that is wrap-around and is not checked.

## Timing
- Accumulate latency: a product is visible in `acc` at the edge that samples its `ack`.
- The counter raises `ack__mac` at the same edge that takes the final `ack`. At that edge this block accumulates the final term.
- At the next falling edge, `rise` is seen and `y`/`y_valid` are registered. Result latency is 1 clock after the final `ack` edge.
- `y_valid` has no backpressure. It stays high until `fall` or reset.
- `ack` and `ack__mac` high simultaneously:
  - In ACCUM with `rise`: the `ack` is dropped.
  - In DONE: the `ack` is dropped.
- Reset mid-accumulation discards any partial sum.

## Configuration
- `LAYER1_MAC_SATURATE_EN` defined: narrowing clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1], i.e. −128..127 at defaults.
- Not defined: narrowing takes the low `WIDTH` bits, with two's-complement wrap.
- Accumulation is identical in both builds. Only the fmt() narrowing step changes.

## Test plan
- Positive sum: 3 acks with x=16, w=16 (1.0·1.0), counter raises `ack__mac` at the 3rd edge. `acc`=768; one edge later `y`=48 (3.0) and `y_valid`=1.
- Negative / floor: 3 acks with x=−16, w=16 → `y`=−48. A single ack with x=1, w=1 (acc=1) → `y`=0; with x=−1, w=1 (acc=−1) → `y`=−1.
- Overflow: 3 acks with x=127, w=127 (acc=48387, shifted 3024).
  - Macro defined: `y`=127.
  - Macro undefined: `y`=−48 (0xD0).
- Ignore in DONE: after `y_valid`=1, pulse `ack` with x=16, w=16 for 2 cycles. `y` and `acc` are unchanged.
- Re-arm: drop `ack__mac`. Next edge gives `y_valid`=0 and `acc`=0. A fresh 3-term run yields the new result.
- Reset mid-operation: 2 acks with x=16, w=16, then `rst`=0 for one edge.
  - `acc`=0, `y`=0, `y_valid`=0.
  - A subsequent 3-term run gives `y`=48.

Source files
------------

// File: rtl/layer1_mac.sv
// layer1_mac: signed x*w multiply-accumulate for one layer-1 neuron, rescaled to fixed point on counter completion.
// Optional build macro LAYER1_MAC_SATURATE_EN clamps the narrowed result instead of wrapping it.
module layer1_mac #(
  parameter int WIDTH     = 8,
  parameter int FRAC      = 4,
  parameter int ACC_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ack,
  input  logic                    ack__mac,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] w,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid
);

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_stateNext;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [ACC_WIDTH-1:0]   w_accNext;
  logic signed [WIDTH-1:0]       r_y;
  logic signed [WIDTH-1:0]       w_yNext;
  logic                          r_yValid;
  logic                          w_yValidNext;
  logic                          r_macD;
  logic                          w_rise;
  logic                          w_fall;
  logic signed [2*WIDTH-1:0]     w_product;
  logic signed [ACC_WIDTH-1:0]   w_productExt;
  logic signed [ACC_WIDTH-1:0]   w_shifted;
  logic signed [WIDTH-1:0]       w_yFmt;

  assign w_rise       = ack__mac & ~r_macD;
  assign w_fall       = ~ack__mac & r_macD;
  assign w_product    = x * w;
  assign w_productExt = ACC_WIDTH'(w_product);
  // Arithmetic shift floors toward minus infinity, so -1/16 becomes -1 rather than 0.
  assign w_shifted    = r_acc >>> FRAC;

`ifdef LAYER1_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

  always_comb begin
    w_yFmt = WIDTH'(w_shifted);
    if (w_shifted > Y_MAX) begin
      w_yFmt = WIDTH'(Y_MAX);
    end else if (w_shifted < Y_MIN) begin
      w_yFmt = WIDTH'(Y_MIN);
    end
  end
`else
  assign w_yFmt = WIDTH'(w_shifted);
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_accNext    = r_acc;
    w_yNext      = r_y;
    w_yValidNext = r_yValid;
    unique case (r_state)
      ACCUM: begin
        // Completion wins over a coincident ack: that ack is dropped.
        if (w_rise) begin
          w_stateNext  = DONE;
          w_yNext      = w_yFmt;
          w_yValidNext = 1'b1;
        end else if (ack) begin
          w_accNext = r_acc + w_productExt;
        end
      end
      DONE: begin
        if (w_fall) begin
          w_stateNext  = ACCUM;
          w_accNext    = '0;
          w_yValidNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = ACCUM;
      end
    endcase
  end

  // Falling-edge update keeps this stage in lockstep with the term counter.
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_state  <= ACCUM;
      r_acc    <= '0;
      r_y      <= '0;
      r_yValid <= 1'b0;
      r_macD   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_acc    <= w_accNext;
      r_y      <= w_yNext;
      r_yValid <= w_yValidNext;
      r_macD   <= ack__mac;
    end
  end

  assign y       = r_y;
  assign y_valid = r_yValid;

endmodule

// File: tb/tb_layer1_mac.sv
// Directed bench for layer1_mac: table of term runs plus hand-written done/re-arm/reset sequences.
module tb_layer1_mac;

  localparam int WIDTH     = 8;
  localparam int FRAC      = 4;
  localparam int ACC_WIDTH = 18;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ack;
  logic                    ack__mac;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] w;
  logic signed [WIDTH-1:0] y;
  logic                    y_valid;

  int checks = 0;
  int errors = 0;
  int lastY  = 0;

  typedef struct {
    int n;
    int xv;
    int wv;
    int expY;
  } vec_t;

  vec_t vecs[9];

  layer1_mac #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack),
    .ack__mac(ack__mac),
    .x       (x),
    .w       (w),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // One active (falling) edge; returns at the following rising edge where outputs are stable.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input int expY, input logic expV);
    logic signed [WIDTH-1:0] e;
    e = WIDTH'(expY);
    checks++;
    if (y !== e || y_valid !== expV) begin
      errors++;
      $display("[TB] FAIL %s: got y=%0d valid=%b, expected y=%0d valid=%b", name, y, y_valid, e, expV);
    end
  endtask

  // Runs n acks, then raises ack__mac as the counter would; optionally re-arms afterwards.
  task automatic applyStimulus(input string name, input int n, input int xv, input int wv,
                               input int expY, input bit rearm, input bit ackOnRise);
    for (int i = 0; i < n; i++) begin
      ack      = 1'b1;
      ack__mac = 1'b0;
      x        = WIDTH'(xv);
      w        = WIDTH'(wv);
      tick();
    end
    checkOutput({name, " pre"}, lastY, 1'b0);
    ack      = ackOnRise;
    ack__mac = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput({name, " result"}, expY, 1'b1);
    lastY = expY;
    if (rearm) begin
      ack__mac = 1'b0;
      tick();
      checkOutput({name, " rearm"}, expY, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{3,   16,  16,   48};
    vecs[1] = '{3,  -16,  16,  -48};
    vecs[2] = '{1,    1,   1,    0};
    vecs[3] = '{1,   -1,   1,   -1};
`ifdef LAYER1_MAC_SATURATE_EN
    vecs[4] = '{3,  127, 127,  127};
    vecs[5] = '{2, -128,-128,  127};
    vecs[6] = '{2, -128, 127, -128};
`else
    vecs[4] = '{3,  127, 127,  -48};
    vecs[5] = '{2, -128,-128,    0};
    vecs[6] = '{2, -128, 127,   16};
`endif
    vecs[7] = '{2,    5,   7,    4};
    vecs[8] = '{2,   -5,   7,   -5};

    rst      = 1'b0;
    ack      = 1'b0;
    ack__mac = 1'b0;
    x        = '0;
    w        = '0;
    tick();
    tick();
    checkOutput("reset", 0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("idle", 0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].n, vecs[i].xv, vecs[i].wv,
                    vecs[i].expY, 1'b1, 1'b0);
    end

    // Coincident ack on the rise edge is dropped, then acks in DONE are ignored.
    applyStimulus("ackOnRise", 3, 16, 16, 48, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1;
      x   = 8'sd16;
      w   = 8'sd16;
      tick();
      checkOutput($sformatf("doneIgnore%0d", i), 48, 1'b1);
    end
    ack      = 1'b0;
    ack__mac = 1'b0;
    tick();
    checkOutput("doneRearm", 48, 1'b0);
    applyStimulus("freshRun", 3, -16, 16, -48, 1'b1, 1'b0);

    // Reset in the middle of accumulation discards the partial sum.
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1;
      x   = 8'sd16;
      w   = 8'sd16;
      tick();
    end
    ack = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("midReset", 0, 1'b0);
    rst   = 1'b1;
    lastY = 0;
    applyStimulus("afterReset", 3, 16, 16, 48, 1'b1, 1'b0);

    // ack__mac already high when leaving reset produces an immediate zero result.
    rst      = 1'b0;
    ack__mac = 1'b1;
    tick();
    checkOutput("resetMacHigh", 0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("riseOnExit", 0, 1'b1);
    ack__mac = 1'b0;
    tick();
    checkOutput("exitRearm", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
